// File: rtl/normalize27_if.sv
// Handshake and data bundle between subtract26, normalize27 and the result consumer.
// The master side drives the inputs and out_ready; the slave side is the normalizer.
interface normalize27_if #(
    parameter int WIDTH = 27,
    parameter int EW    = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] S_in;
    logic             Cout_in;
    logic [EW-1:0]    E_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] M_out;
    logic [EW-1:0]    E_out;
    logic             sign_out;
    logic             zero_out;
    logic             uflow_out;

    modport master (
        output in_valid, S_in, Cout_in, E_in, out_ready,
        input  in_ready, out_valid, M_out, E_out,
        input  sign_out, zero_out, uflow_out
    );

    modport slave (
        input  in_valid, S_in, Cout_in, E_in, out_ready,
        output in_ready, out_valid, M_out, E_out,
        output sign_out, zero_out, uflow_out
    );
endinterface

// File: rtl/normalize27.sv
// Sign-magnitude normalizer for the subtract26 difference.
// Shifts left one bit per clock until the MSB is set, the value is zero or the exponent runs out.
module normalize27 #(
    parameter int WIDTH = 27,
    parameter int EW    = 8
) (
    input logic         clk,
    input logic         reset_n,
    normalize27_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mag_q;
    logic [EW-1:0]    exp_q;
    logic             sign_q;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] m_out_q;
    logic [EW-1:0]    e_out_q;
    logic             sign_out_q;
    logic             zero_out_q;
    logic             uflow_out_q;

    // Two's complement magnitude; the most negative value maps onto itself.
    logic [WIDTH-1:0] mag_in_d;
    assign mag_in_d = bus.Cout_in ? bus.S_in : (~bus.S_in + 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_out_q     <= '0;
            e_out_q     <= '0;
            sign_out_q  <= 1'b0;
            zero_out_q  <= 1'b0;
            uflow_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_q      <= mag_in_d;
                        sign_q     <= ~bus.Cout_in;
                        exp_q      <= bus.E_in;
                        in_ready_q <= 1'b0;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    if (mag_q == '0) begin
                        m_out_q     <= '0;
                        e_out_q     <= '0;
                        sign_out_q  <= sign_q;
                        zero_out_q  <= 1'b1;
                        uflow_out_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (mag_q[WIDTH-1] || exp_q == '0) begin
                        m_out_q     <= mag_q;
                        e_out_q     <= exp_q;
                        sign_out_q  <= sign_q;
                        zero_out_q  <= 1'b0;
                        uflow_out_q <= ~mag_q[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                        exp_q <= exp_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.M_out     = m_out_q;
    assign bus.E_out     = e_out_q;
    assign bus.sign_out  = sign_out_q;
    assign bus.zero_out  = zero_out_q;
    assign bus.uflow_out = uflow_out_q;
endmodule

// File: tb/tb_normalize27.sv
// Scoreboard bench for normalize27: expected results queued at drive time,
// popped and compared when out_valid appears.
module tb_normalize27;
    localparam int WIDTH = 27;
    localparam int EW    = 8;

    typedef struct {
        logic [WIDTH-1:0] m;
        logic [EW-1:0]    e;
        logic             s;
        logic             z;
        logic             u;
        int               lat;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    normalize27_if #(.WIDTH(WIDTH), .EW(EW)) bus ();

    normalize27 #(.WIDTH(WIDTH), .EW(EW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [WIDTH-1:0] s, logic c, logic [EW-1:0] e);
        exp_t r;
        logic [WIDTH-1:0] m;
        m     = c ? s : (~s + 27'd1);
        r.s   = ~c;
        r.z   = 1'b0;
        r.u   = 1'b0;
        r.e   = e;
        r.lat = 1;
        if (m == '0) begin
            r.m = '0;
            r.e = '0;
            r.z = 1'b1;
            return r;
        end
        while (!m[WIDTH-1] && r.e != 0) begin
            m     = m << 1;
            r.e   = r.e - 8'd1;
            r.lat = r.lat + 1;
        end
        r.u = ~m[WIDTH-1];
        r.m = m;
        return r;
    endfunction

    function automatic exp_t mk(logic [WIDTH-1:0] m, logic [EW-1:0] e,
                                logic s, logic z, logic u, int lat);
        exp_t r;
        r.m = m; r.e = e; r.s = s; r.z = z; r.u = u; r.lat = lat;
        return r;
    endfunction

    // Drive one difference, measure latency, compare against the queue head.
    task automatic run_txn(input logic [WIDTH-1:0] s, input logic c,
                           input logic [EW-1:0] e, input exp_t x,
                           input bit consume);
        exp_t g;
        int   lat;
        int   w;
        logic [WIDTH-1:0] m_hold;
        sb.push_back(x);
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait got=%b want=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.S_in     = s;
        bus.Cout_in  = c;
        bus.E_in     = e;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid === 1'b1) break;
        end
        g = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || lat !== g.lat) begin
            errors++;
            $display("FAIL latency S=%h got=%0d want=%0d", s, lat, g.lat);
        end
        checks++;
        if (bus.M_out !== g.m || bus.E_out !== g.e) begin
            errors++;
            $display("FAIL mag_exp S=%h got=%h/%0d want=%h/%0d",
                     s, bus.M_out, bus.E_out, g.m, g.e);
        end
        checks++;
        if ({bus.sign_out, bus.zero_out, bus.uflow_out} !== {g.s, g.z, g.u}) begin
            errors++;
            $display("FAIL flags S=%h got=%b%b%b want=%b%b%b", s,
                     bus.sign_out, bus.zero_out, bus.uflow_out, g.s, g.z, g.u);
        end
        if (consume) begin
            m_hold = bus.M_out;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.M_out !== m_hold) begin
                errors++;
                $display("FAIL consume got=%b/%b/%h want=0/1/%h",
                         bus.out_valid, bus.in_ready, bus.M_out, m_hold);
            end
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.S_in      = '0;
        bus.Cout_in   = 1'b0;
        bus.E_in      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.M_out, bus.E_out,
             bus.sign_out, bus.zero_out, bus.uflow_out} !== {2'b01, 38'd0}) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%h/%0d want=0/1/0/0",
                     bus.out_valid, bus.in_ready, bus.M_out, bus.E_out);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        run_txn(27'h7FFFFFF, 1'b0, 8'd30, mk(27'h4000000, 8'd4, 1'b1, 1'b0, 1'b0, 27), 1'b1);
        // Mid-cycle assert: outputs must clear without a clock edge.
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.M_out, bus.E_out,
             bus.sign_out, bus.zero_out, bus.uflow_out} !== {2'b01, 38'd0}) begin
            errors++;
            $display("FAIL async_reset got=%b/%b/%h/%0d/%b want=0/1/0/0/0",
                     bus.out_valid, bus.in_ready, bus.M_out, bus.E_out, bus.sign_out);
        end
        bus.in_valid = 1'b1;
        bus.S_in     = 27'h4000000;
        bus.Cout_in  = 1'b1;
        bus.E_in     = 8'd10;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_accept got=%b/%b want=0/0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.M_out !== 27'h4000000 || bus.E_out !== 8'd10) begin
            errors++;
            $display("FAIL post_reset_txn got=%b/%h/%0d want=1/4000000/10",
                     bus.out_valid, bus.M_out, bus.E_out);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_directed();
        run_txn(27'h0000001, 1'b1, 8'd100, mk(27'h4000000, 8'd74, 1'b0, 1'b0, 1'b0, 27), 1'b1);
        run_txn(27'h0000000, 1'b1, 8'd55, mk(27'h0000000, 8'd0, 1'b0, 1'b1, 1'b0, 1), 1'b1);
        run_txn(27'h0000100, 1'b1, 8'd3, mk(27'h0000800, 8'd0, 1'b0, 1'b0, 1'b1, 4), 1'b1);
        run_txn(27'h4000000, 1'b0, 8'd9, mk(27'h4000000, 8'd9, 1'b1, 1'b0, 1'b0, 1), 1'b1);
        run_txn(27'h0000005, 1'b1, 8'd0, mk(27'h0000005, 8'd0, 1'b0, 1'b0, 1'b1, 1), 1'b1);
        run_txn(27'h4000000, 1'b1, 8'd0, mk(27'h4000000, 8'd0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] m0;
        logic [EW-1:0]    e0;
        logic [2:0]       f0;
        run_txn(27'h0ABCDEF, 1'b1, 8'd20, model(27'h0ABCDEF, 1'b1, 8'd20), 1'b0);
        m0 = bus.M_out;
        e0 = bus.E_out;
        f0 = {bus.sign_out, bus.zero_out, bus.uflow_out};
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.S_in     = 27'($urandom);
            bus.Cout_in  = 1'($urandom);
            bus.E_in     = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.M_out !== m0 ||
                bus.E_out !== e0 || {bus.sign_out, bus.zero_out, bus.uflow_out} !== f0) begin
                errors++;
                $display("FAIL hold_%0d got=%b/%b/%h/%0d want=1/0/%h/%0d",
                         i, bus.out_valid, bus.in_ready, bus.M_out, bus.E_out, m0, e0);
            end
        end
        // in_valid stays high across the consume edge: it must not be taken.
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.M_out !== m0) begin
            errors++;
            $display("FAIL no_overlap got=%b/%b/%h want=0/1/%h",
                     bus.out_valid, bus.in_ready, bus.M_out, m0);
        end
    endtask

    task automatic test_abort();
        bit seen;
        bus.in_valid = 1'b1;
        bus.S_in     = 27'h0000001;
        bus.Cout_in  = 1'b1;
        bus.E_in     = 8'd100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got=%b/%b want=1/0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk) reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_result got=%b/%b want=0/1", seen, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] s;
        logic             c;
        logic [EW-1:0]    e;
        for (int i = 0; i < 10; i++) begin
            s = 27'($urandom) >> $urandom_range(0, 26);
            c = 1'($urandom);
            e = 8'($urandom_range(0, 40));
            run_txn(s, c, e, model(s, c, e), 1'b1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
